// File: rtl/lab_buffer_sched_pkg.sv
// Shared types for the LAB buffer digitize scheduler: buffer and FSM state
// encodings plus the round-robin pick helper.
package lab_buffer_sched_pkg;

    localparam int BUF_ID_BITS = 2;
    localparam int NBUF_FIXED  = 4;

    typedef enum logic [1:0] {
        BUF_FREE       = 2'd0,
        BUF_PENDING    = 2'd1,
        BUF_DIGITIZING = 2'd2,
        BUF_FULL       = 2'd3
    } buf_state_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_ABORT     = 3'd4
    } fsm_state_e;

    // First requesting buffer at or after ptr, wrapping from the top ID to 0.
    // The loop walks offsets from farthest to nearest so the nearest hit wins.
    function automatic logic [BUF_ID_BITS-1:0] rr_pick(
        input logic [NBUF_FIXED-1:0]  req,
        input logic [BUF_ID_BITS-1:0] ptr
    );
        logic [BUF_ID_BITS-1:0] idx;
        rr_pick = ptr;
        for (int off = NBUF_FIXED - 1; off >= 0; off--) begin
            idx = ptr + BUF_ID_BITS'(off);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/lab_buf_id_fifo.sv
// In-order FIFO of completed buffer IDs, one entry per buffer, so it can
// never overflow while each buffer is queued at most once.
module lab_buf_id_fifo
    import lab_buffer_sched_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [BUF_ID_BITS-1:0] push_data_i,
    input  logic                   pop_i,
    output logic [BUF_ID_BITS-1:0] head_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int DEPTH = NBUF_FIXED;

    logic [BUF_ID_BITS-1:0] mem_q [DEPTH];
    logic [1:0]             wr_ptr_q;
    logic [1:0]             rd_ptr_q;
    logic [2:0]             count_q;
    logic                   do_push;
    logic                   do_pop;

    assign empty_o = (count_q == 3'd0);
    assign full_o  = (count_q == 3'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage, pointers and occupancy.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register sees pre-edge values of the others regardless of order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: storage is reset too, because head_o is visible while empty
            // and must read 0 right after reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lab_buffer_sched.sv
// Digitize scheduler: tracks four LAB buffers, starts one digitization at a
// time in round-robin order and hands completed buffers to readout oldest-first.
module lab_buffer_sched
    import lab_buffer_sched_pkg::*;
#(
    parameter int NBUF           = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int DROP_CNT_BITS  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NBUF-1:0]          digitize_i,
    output logic                     dig_start_o,
    output logic [BUF_ID_BITS-1:0]   dig_buf_o,
    input  logic                     dig_done_i,
    output logic                     ready_o,
    output logic [BUF_ID_BITS-1:0]   ready_buf_o,
    input  logic                     release_i,
    output logic                     timeout_o,
    input  logic                     timeout_clr_i,
    output logic [DROP_CNT_BITS-1:0] drop_cnt_o,
    output logic [2*NBUF-1:0]        buf_state_o
);

    localparam int TO_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DSUM_W  = DROP_CNT_BITS + 3;

    fsm_state_e               state_q, state_d;
    logic [BUF_ID_BITS-1:0]   grant_q, grant_d;
    logic [BUF_ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TO_BITS-1:0]       to_cnt_q, to_cnt_d;
    buf_state_e               buf_q [NBUF];
    buf_state_e               buf_d [NBUF];
    logic                     timeout_q, timeout_d;
    logic [DROP_CNT_BITS-1:0] drop_q, drop_d;

    logic [NBUF-1:0]          pending;
    logic [NBUF-1:0]          drop_mask;
    logic [DSUM_W-1:0]        drop_sum;
    logic                     start_entry;
    logic                     abort;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic [BUF_ID_BITS-1:0]   fifo_head;
    logic                     fifo_empty;
    logic                     fifo_full;

    lab_buf_id_fifo u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (grant_q),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign fifo_pop    = release_i && !fifo_empty;
    assign ready_o     = !fifo_empty;
    assign ready_buf_o = fifo_head;
    assign dig_buf_o   = grant_q;
    assign timeout_o   = timeout_q;
    assign drop_cnt_o  = drop_q;

    // Pack per-buffer states onto the status port and flag PENDING buffers.
    always_comb begin
        buf_state_o = '0;
        pending     = '0;
        for (int n = 0; n < NBUF; n++) begin
            buf_state_o[2*n +: 2] = buf_q[n];
            pending[n]            = (buf_q[n] == BUF_PENDING);
        end
    end

    // Scheduler FSM: next state, grant, round-robin pointer and timeout count.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        to_cnt_d    = to_cnt_q;
        dig_start_o = 1'b0;
        fifo_push   = 1'b0;
        abort       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    grant_d = rr_pick(pending, rr_ptr_q);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                dig_start_o = 1'b1;
                rr_ptr_d    = grant_q + 2'd1;
                to_cnt_d    = '0;
                state_d     = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (dig_done_i) begin
                    state_d = ST_COMMIT;
                end else if (to_cnt_q == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ABORT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                fifo_push = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ABORT: begin
                abort   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign start_entry = (state_q == ST_IDLE) && (state_d == ST_START);

    // Per-buffer state transitions, dropped-request counting and timeout flag.
    // Each transition is gated on a distinct current state, so they never collide.
    always_comb begin
        drop_mask = '0;
        for (int n = 0; n < NBUF; n++) begin
            buf_d[n]     = buf_q[n];
            drop_mask[n] = digitize_i[n] && (buf_q[n] != BUF_FREE);
            if (digitize_i[n] && buf_q[n] == BUF_FREE)       buf_d[n] = BUF_PENDING;
            if (start_entry && grant_d == BUF_ID_BITS'(n))   buf_d[n] = BUF_DIGITIZING;
            if (fifo_push && grant_q == BUF_ID_BITS'(n))     buf_d[n] = BUF_FULL;
            if (abort && grant_q == BUF_ID_BITS'(n))         buf_d[n] = BUF_FREE;
            if (fifo_pop && fifo_head == BUF_ID_BITS'(n))    buf_d[n] = BUF_FREE;
        end

        drop_sum = DSUM_W'(drop_q);
        for (int n = 0; n < NBUF; n++) drop_sum = drop_sum + DSUM_W'(drop_mask[n]);
        if (drop_sum > DSUM_W'({DROP_CNT_BITS{1'b1}})) drop_d = '1;
        else                                           drop_d = drop_sum[DROP_CNT_BITS-1:0];

        timeout_d = timeout_q;
        if (timeout_clr_i) timeout_d = 1'b0;
        if (abort)         timeout_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            drop_q    <= '0;
            for (int n = 0; n < NBUF; n++) buf_q[n] <= BUF_FREE;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
            for (int n = 0; n < NBUF; n++) buf_q[n] <= buf_d[n];
        end
    end

    // A completion is never queued while every FIFO slot is already taken.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: doc/lab_buffer_sched.md
# lab_buffer_sched

Digitize scheduler for the four LAB sample buffers. It sits between the command receiver's per-buffer digitize pulses and the single LAB digitizer. It tracks the state of every buffer and starts one digitization at a time, using round-robin order. Completed buffers are presented to the readout bus logic oldest-first, and each one is freed when the event is cleared.

## Interface
Parameters:
- NBUF, 4, number of sample buffers (buffer ID width is 2; fixed for this version)
- TIMEOUT_CYCLES, 65535, clk_i cycles allowed between dig_start_o and dig_done_i before abort
- DROP_CNT_BITS, 8, width of the dropped-request counter

Ports:
- clk_i  in  1  system clock (33 MHz local bus clock)
- rst_i  in  1  reset, asynchronous, active-high
- digitize_i  in  4  one-cycle request pulses, bit n = buffer n
- dig_start_o  out  1  one-cycle pulse that starts the digitizer
- dig_buf_o  out  2  buffer being digitized; valid in START and WAIT_DONE
- dig_done_i  in  1  one-cycle pulse from the digitizer marking completion
- ready_o  out  1  at least one buffer is FULL and queued for readout
- ready_buf_o  out  2  oldest FULL buffer; valid when ready_o=1
- release_i  in  1  one-cycle pulse (event clear) that frees the ready_buf_o buffer
- timeout_o  out  1  sticky flag set on a digitizer timeout
- timeout_clr_i  in  1  clears timeout_o
- drop_cnt_o  out  DROP_CNT_BITS  count of dropped requests, saturating
- buf_state_o  out  8  per-buffer state, buffer n at [2n+1:2n]: 0 FREE, 1 PENDING, 2 DIGITIZING, 3 FULL

## Operation
- Buffer state per buffer:
  - FREE→PENDING when its digitize_i bit is sampled.
  - PENDING→DIGITIZING on entry to START.
  - DIGITIZING→FULL in COMMIT.
  - FULL→FREE on release_i.
- A request for a buffer that is not FREE, judged on the pre-edge state, is dropped and drop_cnt_o increments by 1.
  - Several bits dropped in the same cycle add the number of dropped bits; the sum saturates at all-ones.
  - A release_i and a request for the same buffer in the same cycle: the release takes effect and the request is dropped.
- FSM:
  - IDLE: any PENDING → START. The granted buffer is the first PENDING buffer at or after rr_ptr, wrapping 3→0.
  - START: dig_start_o=1 and dig_buf_o=grant. Go to WAIT_DONE and set rr_ptr = grant+1 mod 4.
  - WAIT_DONE: dig_done_i → COMMIT. Timeout counter reaching TIMEOUT_CYCLES → ABORT.
  - COMMIT: push grant into the completion FIFO, buffer → FULL, then → IDLE.
  - ABORT: buffer → FREE (no push), set timeout_o, then → IDLE.
- Completion FIFO: 4 entries × 2 bits, in order. Capacity equals NBUF, so it cannot overflow.
  - ready_o = !empty; ready_buf_o = head entry.
  - release_i with ready_o=0 is ignored.
- timeout_clr_i clears timeout_o. If a set and a clear occur in the same cycle, the set wins.
- dig_done_i outside WAIT_DONE is ignored.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, all buffers FREE, FIFO empty, timeout counter 0.
  - dig_start_o 0, dig_buf_o 0, ready_o 0, ready_buf_o 0, timeout_o 0, drop_cnt_o 0, buf_state_o 0.
- Request at edge N: buffer shows PENDING after edge N. The FSM leaves IDLE at edge N+1, so dig_start_o is high during cycle N+1→N+2.
- Request-to-start latency is 2 cycles with no other pending work.
- dig_done_i sampled at edge M: COMMIT runs during M→M+1, and ready_o rises after edge M+1.
- Timeout counter:
  - Clears on START and increments each WAIT_DONE cycle.
  - ABORT is taken when count = TIMEOUT_CYCLES-1 and dig_done_i=0.
  - dig_done_i on that same edge wins and goes to COMMIT.
- release_i at edge R: buffer is FREE and the FIFO pops after R. ready_o/ready_buf_o update in the same cycle.
- Back-to-back: minimum spacing between dig_start_o pulses is 4 cycles (START, WAIT_DONE, COMMIT, IDLE).
- Asserting rst_i mid-digitization immediately returns every register to its reset value. There is no dig_start_o glitch.

## Structure
- Shared package: buffer state encodings (FREE/PENDING/DIGITIZING/FULL), FSM state encodings, and BUF_ID_BITS=2.
- One sub-module, lab_buf_id_fifo: a 4×2 in-order FIFO with push, pop, head, empty and full. full is used only for assertions.
- Round-robin grant, buffer state array, counters and FSM live in the top level. Target size is about 200 lines.

## Test plan
- Single request: digitize_i=4'b0100 → dig_start_o 2 cycles later with dig_buf_o=2. Then dig_done_i → ready_o=1, ready_buf_o=2, buf_state_o=8'b00_11_00_00 after COMMIT. Then release_i → ready_o=0, buf_state_o=0.
- Simultaneous request digitize_i=4'b1011 with rr_ptr=0 → starts in order 0, 1, 3. After completions, pop order is 0, 1, 3. rr_ptr ends at 0.
- Duplicate request: pulse buffer 1 while it is DIGITIZING, then again while FULL → drop_cnt_o=2 and no extra dig_start_o. Fire 300 drops → drop_cnt_o holds at 255.
- Timeout with TIMEOUT_CYCLES=16 and no dig_done_i → ABORT after 16 WAIT_DONE cycles, buffer FREE, timeout_o=1, ready_o=0. timeout_clr_i → timeout_o=0.
- Same-cycle release_i and digitize_i for the head buffer 0 → buffer 0 FREE, drop_cnt_o+1, no new start.
- rst_i asserted in WAIT_DONE with 2 FULL buffers queued → all outputs return to reset values at once. A later dig_done_i is ignored.
